score_streamer: RTL and testbench
=================================

// Module: score_streamer
// PURPOSE
//  Transmit side of the class-score stream consumed by the argmax index decoder.
//  Buffers one frame of NUM_CLASSES signed scores written by the FC layer.
//  On start: pulses a decoder clear, then streams scores one per cycle with an enable strobe, in index order 0..N-1.
//  Sits between the FC output stage and the index decoder; the decoder needs no handshake.
// PARAMETERS
//  DATA_W       32  score width, two's complement (matches INTERNAL_BITS)
//  NUM_CLASSES  10  scores per frame, >=2
//  IDX_W        4   address/index width, >= clog2(NUM_CLASSES)
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, asynchronous, active-high
//  wr_en      in   1       buffer write strobe
//  wr_addr    in   IDX_W   buffer write index
//  wr_data    in   DATA_W  signed score to store
//  start      in   1       begin streaming buffered frame (single-cycle pulse)
//  dec_clr    out  1       one-cycle clear to decoder before first score
//  out_en     out  1       score valid strobe (drives decoder en)
//  out_data   out  DATA_W  signed score (drives decoder Data_in)
//  out_idx    out  IDX_W   index of score on out_data (debug/check)
//  busy       out  1       high from accepted start until done
//  done       out  1       one-cycle pulse after last score
//  wr_drop    out  1       sticky: a write was dropped (busy or addr>=NUM_CLASSES)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, stream counter 0; buffer contents undefined (not reset).
//  FSM: IDLE -> CLR -> STREAM -> DONE -> IDLE.
//   IDLE: busy=0. start=1 -> CLR next cycle. Writes accepted only here.
//   CLR: dec_clr=1, busy=1, counter<=0, wr_drop<=0 -> STREAM.
//   STREAM: out_en=1, out_data=buf[cnt], out_idx=cnt, cnt++ each cycle;
//           after cnt==NUM_CLASSES-1 is presented -> DONE. Exactly NUM_CLASSES consecutive out_en cycles.
//   DONE: done=1, busy=1, out_en=0 -> IDLE.
//  Latency: start at cycle T -> dec_clr at T+1, first score T+2, last T+1+N, done T+2+N.
//  All outputs registered; out_data/out_idx hold 0 when out_en=0.
//  Write accepted in IDLE when wr_addr<NUM_CLASSES: buf[wr_addr]<=wr_data next edge;
//   start and wr_en same cycle in IDLE: write completes first, streamed frame includes it.
//  Write while busy or wr_addr>=NUM_CLASSES: ignored, wr_drop<=1 (held until next CLR).
//  start while busy: ignored, no error flag.
//  Data passed unmodified; no arithmetic, no saturation; sign preserved bit-exact.
//  rst mid-stream: immediate return to IDLE, out_en/done/dec_clr drop async; no partial done.
//  Back-to-back frames: start in cycle after done is accepted (FSM already IDLE).
// TESTING
//  1 Write {5,-3,9,0,2,9,-8,1,4,7}, start -> dec_clr 1 cycle, 10 out_en beats idx 0..9 same values, done at T+12; decoder Index=2.
//  2 All scores negative {-10..-1} -> stream bit-exact signed values; decoder Index=9.
//  3 wr_en during STREAM and wr_addr=12 in IDLE -> buffer unchanged, wr_drop=1; next start clears it in CLR cycle.
//  4 start pulsed again at beat 4 -> ignored, single 10-beat frame, one done.
//  5 rst asserted at beat 5 -> out_en=0 immediately, busy=0, no done; fresh start streams full frame.
//  6 Two frames back-to-back (start right after done) with new data -> second frame reflects new writes only.

Source files
------------

// File: rtl/score_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | score_streamer                                                           |
// | Buffers one frame of signed class scores and streams them to the argmax  |
// | decoder: a one-cycle decoder clear, then one score per cycle, then done. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module score_streamer #(
  parameter int DATA_W      = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              dec_clr,
  output logic              out_en,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy,
  output logic              done,
  output logic              wr_drop
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLR    = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  nxt_idx;
  logic              dec_clr_q, dec_clr_d;
  logic              out_en_q, out_en_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_drop_q, wr_drop_d;
  logic              wr_ok;
  logic              wr_bad;

  // Score buffer; deliberately not reset.
  logic [DATA_W-1:0] mem_q [NUM_CLASSES];

  assign wr_ok   = wr_en && (state_q == S_IDLE) && (wr_addr <= LAST_IDX);
  assign wr_bad  = wr_en && !wr_ok;
  assign nxt_idx = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dec_clr_d  = 1'b0;
    out_en_d   = 1'b0;
    out_data_d = '0;
    out_idx_d  = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    wr_drop_d  = wr_drop_q | wr_bad;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLR;
          dec_clr_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_CLR: begin
        state_d    = S_STREAM;
        busy_d     = 1'b1;
        cnt_d      = '0;
        out_en_d   = 1'b1;
        out_data_d = mem_q[0];
        out_idx_d  = '0;
        // A drop seen during the clear cycle itself still gets flagged.
        wr_drop_d  = wr_bad;
      end
      S_STREAM: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d      = nxt_idx;
          out_en_d   = 1'b1;
          out_data_d = mem_q[nxt_idx];
          out_idx_d  = nxt_idx;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dec_clr_q  <= 1'b0;
      out_en_q   <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dec_clr_q  <= dec_clr_d;
      out_en_q   <= out_en_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  assign dec_clr  = dec_clr_q;
  assign out_en   = out_en_q;
  assign out_data = out_data_q;
  assign out_idx  = out_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_drop  = wr_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_score_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_score_streamer                                                        |
// | Directed bench for score_streamer with hand-computed frames.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_score_streamer;

  localparam int DW = 32;
  localparam int NC = 10;
  localparam int IW = 4;

  typedef logic signed [DW-1:0] frame_t [NC];

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          dec_clr;
  logic          out_en;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          busy;
  logic          done;
  logic          wr_drop;

  int n_vec  = 0;
  int n_miss = 0;

  score_streamer #(.DATA_W(DW), .NUM_CLASSES(NC), .IDX_W(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .dec_clr  (dec_clr),
    .out_en   (out_en),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done),
    .wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = IW'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Writes entries 0..NC-2, then drives the last write together with start.
  task automatic load_and_start(input frame_t f);
    for (int i = 0; i < NC - 1; i++) wr(i, f[i]);
    wr_en   = 1'b1;
    wr_addr = IW'(NC - 1);
    wr_data = f[NC-1];
    start   = 1'b1;
  endtask

  // Called in the cycle where start is driven; returns sampled in the done cycle.
  task automatic run_frame(input frame_t exp_v, input int again_beat, input int wr_beat,
                           input int rst_beat, input int exp_arg);
    int                   arg;
    logic signed [DW-1:0] best;
    arg  = 0;
    best = '0;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    chk("clr_dec_clr", 32'(dec_clr), 1);
    chk("clr_busy",    32'(busy), 1);
    chk("clr_out_en",  32'(out_en), 0);
    for (int i = 0; i < NC; i++) begin
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      chk("beat_en",   32'(out_en), 1);
      chk("beat_idx",  32'(out_idx), i);
      chk("beat_data", out_data, exp_v[i]);
      chk("beat_dclr", 32'(dec_clr), 0);
      chk("beat_done", 32'(done), 0);
      if (i == 0) chk("drop_cleared", 32'(wr_drop), 0);
      if (i == 0 || $signed(out_data) > best) begin
        best = $signed(out_data);
        arg  = i;
      end
      if (i == again_beat) start = 1'b1;
      if (i == wr_beat) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 32'd777;
      end
      if (i == rst_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_out_en",  32'(out_en), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_out_dat", out_data, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < NC + 4; k++) begin
          tick();
          chk("rst_no_done", 32'(done), 0);
          chk("rst_no_en",   32'(out_en), 0);
        end
        return;
      end
    end
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    chk("done_pulse",   32'(done), 1);
    chk("done_out_en",  32'(out_en), 0);
    chk("done_out_dat", out_data, 0);
    chk("done_out_idx", 32'(out_idx), 0);
    chk("done_busy",    32'(busy), 1);
    if (wr_beat >= 0) chk("drop_busy_wr", 32'(wr_drop), 1);
    chk("argmax", arg, exp_arg);
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("idle_done", 32'(done), 0);
      chk("idle_en",   32'(out_en), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_dclr", 32'(dec_clr), 0);
    end
  endtask

  frame_t f1, f2, f6a, f6b;

  initial begin
    f1  = '{5, -3, 9, 0, 2, 9, -8, 1, 4, 7};
    f2  = '{-10, -9, -8, -7, -6, -5, -4, -3, -2, -1};
    f6a = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    f6b = '{3, 1, 4, 1, 100, 9, 2, 6, 5, 3};

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    tick();
    tick();
    chk("rst_dec_clr", 32'(dec_clr), 0);
    chk("rst_en",      32'(out_en), 0);
    chk("rst_data",    out_data, 0);
    chk("rst_idx",     32'(out_idx), 0);
    chk("rst_busyq",   32'(busy), 0);
    chk("rst_done",    32'(done), 0);
    chk("rst_drop",    32'(wr_drop), 0);
    rst = 1'b0;
    tick();

    // Mixed-sign frame; the last write shares its cycle with start.
    load_and_start(f1);
    run_frame(f1, -1, -1, -1, 2);
    idle_check(2);

    // Out-of-range address in IDLE is dropped and flagged.
    wr(12, 32'd55);
    chk("drop_oor", 32'(wr_drop), 1);

    // All-negative frame with a write mid-stream and a repeated start.
    load_and_start(f2);
    chk("drop_held", 32'(wr_drop), 1);
    run_frame(f2, 4, 3, -1, 9);
    idle_check(NC + 3);

    // Reset mid-stream, then a fresh start replays the untouched buffer.
    start = 1'b1;
    run_frame(f2, -1, -1, 5, 0);
    start = 1'b1;
    run_frame(f2, -1, -1, -1, 9);
    idle_check(1);

    // Back-to-back frames: second start right after done, with one new write.
    load_and_start(f6a);
    run_frame(f6a, -1, -1, -1, 5);
    tick();
    chk("b2b_idle_busy", 32'(busy), 0);
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd4;
    wr_data = 32'd100;
    run_frame(f6b, -1, -1, -1, 4);
    idle_check(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
